branch_ctrl: RTL

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/branch_ctrl_if.sv | 40 ++++
 rtl/branch_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/branch_ctrl_if.sv
// Branch controller handshake bundle: decode/fetch side signals and redirect outputs.
// Optional statistics outputs exist only when BRANCH_CTRL_STAT_EN is defined.
interface branch_ctrl_if;
    logic        br_valid;
    logic [5:0]  br_op;
    logic        br_jump;
    logic [31:0] br_target;
    logic        opnd_ready;
    logic        realj;
    logic        ds_valid;
    logic        if_ready;
    logic        exc_flush;
    logic        br_stall;
    logic        br_taken;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRANCH_CTRL_STAT_EN
    logic [31:0] stat_taken;
    logic [31:0] stat_nottaken;
    logic [31:0] stat_stall;
`endif

    modport master (
        output br_valid, br_op, br_jump, br_target,
        output opnd_ready, realj, ds_valid, if_ready, exc_flush,
`ifdef BRANCH_CTRL_STAT_EN
        input  stat_taken, stat_nottaken, stat_stall,
`endif
        input  br_stall, br_taken, redirect_valid, redirect_pc
    );

    modport slave (
        input  br_valid, br_op, br_jump, br_target,
        input  opnd_ready, realj, ds_valid, if_ready, exc_flush,
`ifdef BRANCH_CTRL_STAT_EN
        output stat_taken, stat_nottaken, stat_stall,
`endif
        output br_stall, br_taken, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/branch_ctrl.sv
// Branch resolution FSM: stalls for operands, waits for the delay slot, then redirects fetch.
// Define BRANCH_CTRL_STAT_EN to add taken/not-taken/stall statistics counters.
module branch_ctrl (
    input logic         clk,
    input logic         resetn,
    branch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_OPND,
        WAIT_DS,
        REDIRECT
    } state_t;

    state_t state;

    logic is_cond;
    logic eval;
    logic resolve;
    logic taken;

    assign is_cond = |bus.br_op;

    // Delay-slot branches (WAIT_DS/REDIRECT) never reach evaluation.
    assign eval = (state == IDLE && bus.br_valid && (bus.br_jump || is_cond))
               || (state == WAIT_OPND);

    assign resolve = eval && (bus.br_jump || bus.opnd_ready);
    assign taken   = bus.br_jump | (is_cond & bus.opnd_ready & bus.realj);

    assign bus.br_stall = eval && !resolve && !bus.exc_flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state              <= IDLE;
            bus.br_taken       <= 1'b0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= 32'h0;
        end else if (bus.exc_flush) begin
            state              <= IDLE;
            bus.br_taken       <= 1'b0;
            bus.redirect_valid <= 1'b0;
        end else begin
            bus.br_taken <= 1'b0;
            unique case (state)
                IDLE, WAIT_OPND: begin
                    if (resolve) begin
                        if (taken) begin
                            bus.redirect_pc <= bus.br_target;
                            bus.br_taken    <= 1'b1;
                            if (bus.ds_valid) begin
                                state              <= REDIRECT;
                                bus.redirect_valid <= 1'b1;
                            end else begin
                                state <= WAIT_DS;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end else if (eval) begin
                        state <= WAIT_OPND;
                    end
                end
                WAIT_DS: begin
                    if (bus.ds_valid) begin
                        state              <= REDIRECT;
                        bus.redirect_valid <= 1'b1;
                    end
                end
                REDIRECT: begin
                    if (bus.if_ready) begin
                        state              <= IDLE;
                        bus.redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state              <= IDLE;
                    bus.redirect_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRANCH_CTRL_STAT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.stat_taken    <= 32'h0;
            bus.stat_nottaken <= 32'h0;
            bus.stat_stall    <= 32'h0;
        end else begin
            if (resolve && !bus.exc_flush) begin
                if (taken) bus.stat_taken <= bus.stat_taken + 32'd1;
                else       bus.stat_nottaken <= bus.stat_nottaken + 32'd1;
            end
            if (bus.br_stall) bus.stat_stall <= bus.stat_stall + 32'd1;
        end
    end
`endif

endmodule
